// File: rtl/data_unpacker_if.sv
// rtl/data_unpacker_if.sv - valid/ready stream bundle used on both sides of the data unpacker
interface data_unpacker_if #(
  parameter int DATA_W = 256,
  parameter int KEEP_W = 32,
  parameter int TAG_W  = 1
);
  logic [DATA_W-1:0] data;
  logic [TAG_W-1:0]  tag;
  logic [KEEP_W-1:0] keep;
  logic              valid;
  logic              last;
  logic              ready;

  modport master (output data, tag, keep, valid, last, input ready);
  modport slave  (input data, tag, keep, valid, last, output ready);
endinterface

// File: rtl/data_unpacker.sv
// rtl/data_unpacker.sv - word stream to MSB-aligned per-channel lanes, 16-bit or packed 12-bit samples
// Optional input skid buffer: define DATA_UNPACKER_SKID_EN.
module data_unpacker #(
  parameter int CH_COUNT   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_mode_12,
  data_unpacker_if.slave  s_in,
  data_unpacker_if.master m_out
);
  localparam int SW = 16 * CH_COUNT;
  localparam int RW = 12 * CH_COUNT;
  localparam int CW = 2 * RW;
  localparam int KW = 2 * CH_COUNT;
  localparam int OW = CH_COUNT * DATA_WIDTH;

  typedef enum logic [2:0] {
    ST_R0    = 3'd0,
    ST_R1    = 3'd1,
    ST_R2    = 3'd2,
    ST_R3    = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            r;
  logic [RW-1:0]         residue, residue_nxt;
  logic [CH_COUNT-1:0]   flush_keep, flush_keep_nxt;
  logic                  mode_lat, pkt_start, mode_cur;
  logic                  out_free, take, emit;
  logic [SW-1:0]         c_data;
  logic [TAG_WIDTH-1:0]  c_tag;
  logic [KW-1:0]         c_keep;
  logic                  c_valid, c_last, c_ready;
  logic [CW-1:0]         cat;
  int                    n_bytes, n_samp;
  logic [OW-1:0]         d_nxt;
  logic [CH_COUNT-1:0]   keep_nxt;
  logic                  last_nxt;
  logic [TAG_WIDTH-1:0]  tag_nxt;
  logic [DATA_WIDTH-1:0] lane;

`ifdef DATA_UNPACKER_SKID_EN
  logic                 sk_full;
  logic [SW-1:0]        sk_data;
  logic [TAG_WIDTH-1:0] sk_tag;
  logic [KW-1:0]        sk_keep;
  logic                 sk_last;

  // Skid parks a word offered while the core is blocked, so ready never looks at m_out.ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      sk_full <= 1'b0;
      sk_data <= '0;
      sk_tag  <= '0;
      sk_keep <= '0;
      sk_last <= 1'b0;
    end else if (sk_full) begin
      if (c_ready) sk_full <= 1'b0;
    end else if (s_in.valid && !c_ready) begin
      sk_full <= 1'b1;
      sk_data <= s_in.data;
      sk_tag  <= s_in.tag;
      sk_keep <= s_in.keep;
      sk_last <= s_in.last;
    end
  end

  assign s_in.ready = !sk_full;
  assign c_valid    = sk_full || s_in.valid;
  assign c_data     = sk_full ? sk_data : s_in.data;
  assign c_tag      = sk_full ? sk_tag  : s_in.tag;
  assign c_keep     = sk_full ? sk_keep : s_in.keep;
  assign c_last     = sk_full ? sk_last : s_in.last;
`else
  assign s_in.ready = c_ready;
  assign c_valid    = s_in.valid;
  assign c_data     = s_in.data;
  assign c_tag      = s_in.tag;
  assign c_keep     = s_in.keep;
  assign c_last     = s_in.last;
`endif

  assign r        = state[1:0];
  assign out_free = !m_out.valid || m_out.ready;
  assign mode_cur = pkt_start ? cfg_mode_12 : mode_lat;
  assign take     = c_valid && c_ready;
  // Residue only ever holds its low 4*CH*r bits, so OR-ing it under the shifted word splices the stream.
  assign cat = ({{(CW - SW){1'b0}}, c_data} << (4 * CH_COUNT * int'(r))) | {{(CW - RW){1'b0}}, residue};

  always_comb begin
    n_bytes = 0;
    for (int i = 0; i < KW; i++) begin
      if (c_keep[i]) n_bytes++;
    end
    n_samp = (4 * CH_COUNT * int'(r) + 8 * n_bytes) / 12;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_R0;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (out_free) begin
      case (state)
        ST_R3, ST_FLUSH: state_nxt = ST_R0;
        default: begin
          if (take && mode_cur) begin
            if (c_last) state_nxt = (n_samp > CH_COUNT) ? ST_FLUSH : ST_R0;
            else        state_nxt = state_t'(state + 3'd1);
          end
        end
      endcase
    end
  end

  always_comb begin
    c_ready        = out_free && (state != ST_R3) && (state != ST_FLUSH);
    emit           = 1'b0;
    d_nxt          = '0;
    keep_nxt       = '0;
    last_nxt       = 1'b0;
    tag_nxt        = m_out.tag;
    residue_nxt    = residue;
    flush_keep_nxt = flush_keep;
    lane           = '0;
    if (state == ST_R3 || state == ST_FLUSH) begin
      emit        = out_free;
      keep_nxt    = (state == ST_FLUSH) ? flush_keep : '1;
      last_nxt    = (state == ST_FLUSH);
      residue_nxt = '0;
      for (int i = 0; i < CH_COUNT; i++) begin
        lane = '0;
        lane[DATA_WIDTH-1 -: 12] = residue[12*i +: 12];
        d_nxt[i*DATA_WIDTH +: DATA_WIDTH] = lane;
      end
    end else if (take) begin
      emit    = 1'b1;
      tag_nxt = c_tag;
      if (mode_cur) begin
        for (int i = 0; i < CH_COUNT; i++) begin
          lane = '0;
          lane[DATA_WIDTH-1 -: 12] = cat[12*i +: 12];
          d_nxt[i*DATA_WIDTH +: DATA_WIDTH] = lane;
          keep_nxt[i] = !c_last || (i < n_samp);
          if (c_last) flush_keep_nxt[i] = (i < n_samp - CH_COUNT);
        end
        last_nxt    = c_last && (n_samp <= CH_COUNT);
        residue_nxt = last_nxt ? '0 : cat[RW +: RW];
      end else begin
        for (int i = 0; i < CH_COUNT; i++) begin
          lane = '0;
          lane[DATA_WIDTH-1 -: 16] = c_data[16*i +: 16];
          d_nxt[i*DATA_WIDTH +: DATA_WIDTH] = lane;
          keep_nxt[i] = !c_last || (c_keep[2*i] && c_keep[2*i+1]);
        end
        last_nxt = c_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_out.valid <= 1'b0;
      m_out.last  <= 1'b0;
      m_out.keep  <= '0;
      m_out.data  <= '0;
      m_out.tag   <= '0;
      residue     <= '0;
      flush_keep  <= '0;
      mode_lat    <= 1'b0;
      pkt_start   <= 1'b1;
    end else begin
      if (emit) begin
        m_out.valid <= 1'b1;
        m_out.data  <= d_nxt;
        m_out.keep  <= keep_nxt;
        m_out.last  <= last_nxt;
        m_out.tag   <= tag_nxt;
        residue     <= residue_nxt;
        flush_keep  <= flush_keep_nxt;
      end else if (out_free) begin
        m_out.valid <= 1'b0;
      end
      if (take) begin
        pkt_start <= c_last;
        if (pkt_start) mode_lat <= cfg_mode_12;
      end
    end
  end
endmodule

// File: tb/tb_data_unpacker.sv
// tb/tb_data_unpacker.sv - directed and randomized self-checking bench for data_unpacker
module tb_data_unpacker;
  localparam int CH = 16;
  localparam int DW = 16;
  localparam int TW = 1;

  typedef struct {
    logic [255:0] data;
    logic [15:0]  keep;
    logic         last;
    logic [0:0]   tag;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_mode_12 = 1'b0;

  data_unpacker_if #(.DATA_W(256), .KEEP_W(32), .TAG_W(TW)) s_in ();
  data_unpacker_if #(.DATA_W(CH*DW), .KEEP_W(CH), .TAG_W(TW)) m_out ();

  data_unpacker #(.CH_COUNT(CH), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .cfg_mode_12(cfg_mode_12), .s_in(s_in), .m_out(m_out)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  beat_t        exp_q[$];
  logic [255:0] pw[$];
  logic [0:0]   ptg[$];
  bit           rdy_random = 1'b0;
  bit           stalled = 1'b0;
  beat_t        snap;

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Sample idx of the packet's LSB-first bit stream; bits past the last word read as zero.
  function automatic logic [11:0] samp(input int idx, input int k);
    logic [11:0] s;
    int pos;
    int w;
    s = '0;
    for (int bb = 0; bb < 12; bb++) begin
      pos = 12 * idx + bb;
      w   = pos / 256;
      if (w < k) s[bb] = pw[w][pos % 256];
    end
    return s;
  endfunction

  task automatic model_packet(input bit mode, input int k, input logic [31:0] lkeep, input bit complete);
    beat_t bt;
    int b, n, nsamp, nbeats, wi;
    bit is_last;
    b = 0;
    for (int i = 0; i < 32; i++) if (lkeep[i]) b++;
    if (!mode) begin
      for (int j = 0; j < k; j++) begin
        is_last = complete && (j == k - 1);
        bt.data = pw[j];
        for (int i = 0; i < CH; i++) bt.keep[i] = is_last ? (lkeep[2*i] & lkeep[2*i+1]) : 1'b1;
        bt.last = is_last;
        bt.tag  = ptg[j];
        exp_q.push_back(bt);
      end
    end else begin
      if (complete) begin
        n      = (64 * ((k - 1) % 3) + 8 * b) / 12;
        nbeats = (k - 1) + (k - 1) / 3 + 1 + ((n > CH) ? 1 : 0);
        nsamp  = (256 * (k - 1) + 8 * b) / 12;
      end else begin
        nbeats = k + k / 3;
        nsamp  = CH * nbeats;
      end
      for (int j = 0; j < nbeats; j++) begin
        bt.data = '0;
        for (int i = 0; i < CH; i++) begin
          bt.data[16*i +: 16] = {samp(CH*j + i, k), 4'h0};
          bt.keep[i] = (CH*j + i < nsamp);
        end
        bt.last = complete && (j == nbeats - 1);
        wi = (192 * (j + 1) + 255) / 256 - 1;
        if (wi > k - 1) wi = k - 1;
        bt.tag = ptg[wi];
        exp_q.push_back(bt);
      end
    end
  endtask

  task automatic drive_word(input logic [255:0] d, input logic [0:0] tg, input logic [31:0] kp,
                            input bit lst, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    s_in.data  = d;
    s_in.tag   = tg;
    s_in.keep  = kp;
    s_in.last  = lst;
    s_in.valid = 1'b1;
    while (!acc && waited < 200) begin
      #3;
      acc = (s_in.ready === 1'b1);
      @(posedge clk);
      @(negedge clk);
      if (!acc) waited++;
    end
    check("accept", acc, 1);
    s_in.valid = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int q = 0; q < 8; q++) w[32*q +: 32] = $urandom;
    return w;
  endfunction

  always @(negedge clk) begin
    beat_t e;
    if (!rst && stalled) begin
      check("stall_valid", m_out.valid, 1);
      check("stall_data", m_out.data, snap.data);
      check("stall_keep", m_out.keep, snap.keep);
      check("stall_last", m_out.last, snap.last);
      check("stall_tag", m_out.tag, snap.tag);
    end
    stalled = 1'b0;
    m_out.ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!rst && m_out.valid === 1'b1) begin
      if (m_out.ready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat_data", m_out.data, e.data);
          check("beat_keep", m_out.keep, e.keep);
          check("beat_last", m_out.last, e.last);
          check("beat_tag", m_out.tag, e.tag);
        end
      end else begin
        stalled   = 1'b1;
        snap.data = m_out.data;
        snap.keep = m_out.keep;
        snap.last = m_out.last;
        snap.tag  = m_out.tag;
      end
    end
  end

  initial begin
    int waited, total, k, bnum;
    bit mode;
    logic [255:0] w;
    logic [767:0] st;
    logic [32:0] lk33;

    s_in.valid = 1'b0;
    s_in.last  = 1'b0;
    s_in.data  = '0;
    s_in.keep  = '0;
    s_in.tag   = '0;
    repeat (3) @(negedge clk);
    check("reset_valid", m_out.valid, 0);
    check("reset_last", m_out.last, 0);
    check("reset_keep", m_out.keep, 0);
    check("reset_data", m_out.data, 0);
    check("reset_tag", m_out.tag, 0);
    rst = 1'b0;
    @(negedge clk);

    // 16-bit mode: lanes 1..16, full keep, last
    cfg_mode_12 = 1'b0;
    pw.delete(); ptg.delete();
    for (int i = 0; i < CH; i++) w[16*i +: 16] = 16'(i + 1);
    pw.push_back(w); ptg.push_back(1'b1);
    model_packet(1'b0, 1, 32'hFFFF_FFFF, 1'b1);
    drive_word(w, 1'b1, 32'hFFFF_FFFF, 1'b1, waited);
    #1 check("t1_latency_valid", m_out.valid, 1);
    wait_drain();

    // 12-bit mode: three words carrying samples 0..63
    cfg_mode_12 = 1'b1;
    pw.delete(); ptg.delete();
    for (int s = 0; s < 64; s++) st[12*s +: 12] = 12'(s);
    for (int j = 0; j < 3; j++) begin
      pw.push_back(st[256*j +: 256]);
      ptg.push_back(1'(j));
    end
    model_packet(1'b1, 3, 32'hFFFF_FFFF, 1'b1);
    for (int j = 0; j < 3; j++) begin
      drive_word(pw[j], ptg[j], 32'hFFFF_FFFF, j == 2, waited);
      check("t2_no_wait", waited, 0);
    end
    #1 check("t2_ready_low_flush", s_in.ready, 0);
    @(negedge clk);
    #1 check("t2_ready_back", s_in.ready, 1);
    wait_drain();

    // 12-bit single last word, full keep (n=21) and keep 0x3 (n=1)
    for (int t = 0; t < 2; t++) begin
      pw.delete(); ptg.delete();
      w = rand_word();
      pw.push_back(w); ptg.push_back(1'b0);
      model_packet(1'b1, 1, (t == 0) ? 32'hFFFF_FFFF : 32'h0000_0003, 1'b1);
      drive_word(w, 1'b0, (t == 0) ? 32'hFFFF_FFFF : 32'h0000_0003, 1'b1, waited);
      wait_drain();
    end

    // randomized traffic, both modes, random output backpressure
    rdy_random = 1'b1;
    total = 0;
    while (total < 300) begin
      mode = 1'($urandom_range(0, 1));
      k    = $urandom_range(1, 7);
      pw.delete(); ptg.delete();
      for (int j = 0; j < k; j++) begin
        pw.push_back(rand_word());
        ptg.push_back(1'($urandom_range(0, 1)));
      end
      bnum = $urandom_range(1, 32);
      lk33 = (33'd1 << bnum) - 33'd1;
      model_packet(mode, k, lk33[31:0], 1'b1);
      cfg_mode_12 = mode;
      for (int j = 0; j < k; j++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (j > 0) cfg_mode_12 = 1'($urandom_range(0, 1));
        drive_word(pw[j], ptg[j], (j == k - 1) ? lk33[31:0] : 32'hFFFF_FFFF, j == k - 1, waited);
      end
      total += k;
    end
    wait_drain();
    rdy_random = 1'b0;
    @(negedge clk);

    // reset between word 2 and word 3 of a 12-bit packet
    cfg_mode_12 = 1'b1;
    pw.delete(); ptg.delete();
    for (int j = 0; j < 2; j++) begin
      pw.push_back(rand_word());
      ptg.push_back(1'b1);
    end
    model_packet(1'b1, 2, 32'hFFFF_FFFF, 1'b0);
    for (int j = 0; j < 2; j++) drive_word(pw[j], ptg[j], 32'hFFFF_FFFF, 1'b0, waited);
    wait_drain();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", m_out.valid, 0);
    check("rst_mid_last", m_out.last, 0);
    check("rst_mid_keep", m_out.keep, 0);
    check("rst_mid_data", m_out.data, 0);
    check("rst_mid_tag", m_out.tag, 0);
    rst = 1'b0;
    @(negedge clk);
    pw.delete(); ptg.delete();
    w = rand_word();
    w[11:0] = 12'hABC;
    pw.push_back(w); ptg.push_back(1'b0);
    model_packet(1'b1, 1, 32'h0000_0003, 1'b1);
    drive_word(w, 1'b0, 32'h0000_0003, 1'b1, waited);
    #1 check("rst_new_lane0", m_out.data[15:0], 16'hABC0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_unpacker.md
# data_unpacker

TX-side unpacker, the inverse of the RX sample packer. Accepts a 16·CH_COUNT-bit stream of words carrying either 16-bit or tightly packed 12-bit samples. Emits one CH_COUNT-lane beat per cycle, each lane holding its sample MSB-aligned in DATA_WIDTH bits, plus a per-channel keep mask. Sits between the host DMA word stream and the per-channel TX front-end.

## Interface
- CH_COUNT, 16: channels per output beat; even, ≥2.
- DATA_WIDTH, 16: output lane width; ≥16.
- TAG_WIDTH, 1: sideband tag width, carried unchanged.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cfg_mode_12  in  1  1 = packed 12-bit input, 0 = 16-bit input.
- s_in_data  in  16·CH_COUNT  input word; byte 0 in the LSBs.
- s_in_tag  in  TAG_WIDTH  tag.
- s_in_keep  in  2·CH_COUNT  byte-valid mask; contiguous from bit 0; meaningful only with s_in_last.
- s_in_valid / s_in_last  in  1  handshake / end of packet.
- s_in_ready  out  1  word accepted when s_in_valid && s_in_ready.
- m_out_data  out  CH_COUNT·DATA_WIDTH  unpacked lanes.
- m_out_tag  out  TAG_WIDTH  tag of the word that completed the beat.
- m_out_keep  out  CH_COUNT  per-lane valid.
- m_out_valid / m_out_last  out  1  handshake / end of packet.
- m_out_ready  in  1  beat consumed when m_out_valid && m_out_ready.

## Operation
- Lane format: lane i = {sample, (DATA_WIDTH−w) zeros}, where w = 16 or 12.
- 16-bit mode:
  - lane i ← s_in_data[16i+15:16i].
  - keep[i] = 1, except on a last word, where keep[i] = s_in_keep[2i] & s_in_keep[2i+1].
  - last passes through with the beat.
- 12-bit mode, stream model:
  - Input words concatenate LSB-first. Sample k = bits [12k+11:12k] of the stream. Beat j takes samples CH·j … CH·j+CH−1.
  - Internal residue r ∈ {0,1,2,3}, counted in units of 4·CH bits, held in a 12·CH-bit residue register.
- 12-bit mode, state machine on r:
  - r<3: take one input word, emit {word, residue} low 12·CH bits, keep the remaining bits, r ← r+1.
  - r=3: emit the residue alone without taking input; s_in_ready = 0; r ← 0.
  - Result: 3 words → 4 beats.
- Last word in 12-bit mode:
  - b = number of set bytes in s_in_keep.
  - n = floor((4·CH·r + 8·b)/12) valid samples.
  - Beat 1: keep = min(n,CH) low ones.
  - If n>CH: a flush beat follows from the residue with keep = n−CH low ones; m_out_last is set on the flush beat only, and s_in_ready = 0 while the flush is pending.
  - If n≤CH: m_out_last is set on beat 1 and the leftover residue is discarded.
  - After either case, r ← 0.
- Non-last 12-bit beats: keep all ones.
- cfg_mode_12 is latched only at packet start (r=0, no flush pending, no beat held). Changes mid-packet take effect at the next packet.

## Timing
- Reset values: m_out_valid 0, m_out_last 0, m_out_keep 0, m_out_data 0, m_out_tag 0, r 0, flush pending 0, latched mode 0.
- Latency: 1 cycle from input acceptance to m_out_valid.
- Throughput:
  - One beat per cycle when m_out_ready is held high.
  - 16-bit mode: 1 word per cycle.
  - 12-bit mode: 3 words per 4 cycles.
- Hold: output is registered; data, keep, last and tag stay stable while m_out_valid && !m_out_ready.
- s_in_ready = out_free && !(mode12 && (r==3 || flush pending)), where out_free = !m_out_valid || m_out_ready.
- When m_out_ready is low, r and the residue hold their values.
- Simultaneous consume + accept in the same cycle: the new beat loads, with no bubble.
- rst mid-packet: residue discarded; outputs return to reset values on the next edge.

## Configuration
- DATA_UNPACKER_SKID_EN defined:
  - Adds a one-entry input skid buffer, so s_in_ready is a flop output independent of m_out_ready.
  - Latency becomes 1 cycle (skid empty) or 2 cycles (skid occupied).
  - Full throughput is preserved.
- Undefined: no skid buffer; s_in_ready is combinational from m_out_ready, per the Timing rule.

## Test plan
- 16-bit mode, CH=16, one word of lanes 0x0001…0x0010 with last and keep all ones → one beat, lane i = i+1, keep 0xFFFF, last=1, 1-cycle latency.
- 12-bit mode, 3 words carrying samples 0…63, last on word 3 with keep all ones → 4 beats, samples 0–15, 16–31, 32–47, 48–63; s_in_ready low exactly during the 4th beat; last on beat 4 only.
- 12-bit mode, a single word with last, keep all ones, r=0 → n=21: beat keep 0xFFFF with last=0, then flush beat keep 0x001F with last=1.
- 12-bit mode, single last word with keep = 0x0003 (b=2) → n=1: one beat, keep 0x0001, last=1, no flush beat.
- Random m_out_ready toggling over 300 words in both modes → output sample sequence matches the reference model; data is stable during stalls.
- Assert rst between word 2 and word 3 of a 12-bit packet → all outputs 0 on the next cycle. A new packet then starts at r=0 with sample 0 in lane 0.
